// File: rtl/uart_byte_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_link_pkg
// Brief    : Shared RX/TX state encodings, bit divisor macro and RX FIFO depth.
// Revision : 1.0 - initial release
// ============================================================================

`define UART_DIVISOR(clk_freq, baud) ((clk_freq) / (baud))

package uart_byte_link_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int c_FIFO_DEPTH = 4;
    localparam int c_CNT_W      = 16;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Loadable down-counter; ticks when it expires, then auto-reloads a
//            full bit period. Loading DIVISOR/2 yields a mid-bit tick, 0 stops it.
// Revision : 1.0 - initial release
// ============================================================================

module uart_bit_timer #(
    parameter int DIVISOR = 217,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(DIVISOR);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt == CNT_W'(1)) begin
            r_cnt <= c_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/uart_byte_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_link
// Brief    : 8N1 UART with four-phase req/ack byte handshakes in both directions.
//            Define UART_RX_FIFO_EN for a 4-entry RX FIFO ahead of the handshake.
// Revision : 1.0 - initial release
// ============================================================================

module uart_byte_link
    import uart_byte_link_pkg::*;
#(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200,
    parameter int DIVISOR  = `UART_DIVISOR(CLK_FREQ, BAUD)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_byte,
    output logic       rx_req,
    input  logic       rx_ack,
    input  logic [7:0] tx_byte,
    input  logic       tx_req,
    output logic       tx_ack,
    output logic       tx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [c_CNT_W-1:0] c_DIV  = c_CNT_W'(DIVISOR);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(DIVISOR / 2);

    // ---------------- RX ----------------
    logic               r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t          r_rx_state;
    logic [7:0]         r_rx_shift;
    logic [2:0]         r_rx_bits;
    logic               w_rx_tick, w_rx_load, w_rx_fall, w_rx_done;
    logic [c_CNT_W-1:0] w_rx_load_val;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
    assign w_rx_load     = ((r_rx_state == RX_IDLE) && w_rx_fall) ||
                           ((r_rx_state == RX_START) && w_rx_tick && r_rx_s2) ||
                           ((r_rx_state == RX_STOP) && w_rx_tick);
    assign w_rx_load_val = (r_rx_state == RX_IDLE) ? c_HALF : '0;
    assign w_rx_done     = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_s2;

    uart_bit_timer #(.DIVISOR(DIVISOR), .CNT_W(c_CNT_W)) u_rx_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_rx_load),
        .i_load_val (w_rx_load_val),
        .o_tick     (w_rx_tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= 8'h00;
            r_rx_bits  <= 3'd0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (w_rx_tick) begin
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                        r_rx_bits  <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bits  <= r_rx_bits + 3'd1;
                        if (r_rx_bits == 3'd7) r_rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_state <= RX_IDLE;
                        frame_err  <= ~r_rx_s2;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int c_PTR_W = $clog2(c_FIFO_DEPTH);

    logic [7:0]         r_fifo [c_FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr, r_rd;
    logic [c_PTR_W:0]   r_count;
    logic               w_full, w_push, w_pop;

    assign w_full = (r_count == (c_PTR_W + 1)'(c_FIFO_DEPTH));
    assign w_push = w_rx_done && !w_full;
    assign w_pop  = rx_req && rx_ack;

    always_ff @(posedge Clk) begin
        if (w_push) r_fifo[r_wr] <= r_rx_shift;
    end

    // The head stays in the FIFO while presented; a push into an empty FIFO
    // is presented directly so latency matches the holding-register build.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            rx_req  <= 1'b0;
            rx_byte <= 8'h00;
            overrun <= 1'b0;
        end else begin
            overrun <= w_rx_done && w_full;
            if (w_push) r_wr <= r_wr + c_PTR_W'(1);
            if (w_pop) begin
                rx_req <= 1'b0;
                r_rd   <= r_rd + c_PTR_W'(1);
            end else if (!rx_req && !rx_ack) begin
                if (r_count != '0) begin
                    rx_req  <= 1'b1;
                    rx_byte <= r_fifo[r_rd];
                end else if (w_push) begin
                    rx_req  <= 1'b1;
                    rx_byte <= r_rx_shift;
                end
            end
            r_count <= r_count + (c_PTR_W + 1)'(w_push) - (c_PTR_W + 1)'(w_pop);
        end
    end
`else
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_req  <= 1'b0;
            rx_byte <= 8'h00;
            overrun <= 1'b0;
        end else begin
            overrun <= w_rx_done && (rx_req || rx_ack);
            if (rx_req && rx_ack) begin
                rx_req <= 1'b0;
            end else if (w_rx_done && !rx_req && !rx_ack) begin
                rx_req  <= 1'b1;
                rx_byte <= r_rx_shift;
            end
        end
    end
`endif

    // ---------------- TX ----------------
    tx_state_t          r_tx_state;
    logic [7:0]         r_tx_shift;
    logic [2:0]         r_tx_bits;
    logic               w_tx_tick, w_tx_load, w_tx_accept;
    logic [c_CNT_W-1:0] w_tx_load_val;

    assign w_tx_accept   = tx_req && !tx_ack && (r_tx_state == TX_IDLE);
    assign w_tx_load     = w_tx_accept || ((r_tx_state == TX_STOP) && w_tx_tick);
    assign w_tx_load_val = w_tx_accept ? c_DIV : '0;

    uart_bit_timer #(.DIVISOR(DIVISOR), .CNT_W(c_CNT_W)) u_tx_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_tx_load),
        .i_load_val (w_tx_load_val),
        .o_tick     (w_tx_tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= 8'h00;
            r_tx_bits  <= 3'd0;
            tx         <= 1'b1;
            tx_ack     <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            if (w_tx_accept)          tx_ack <= 1'b1;
            else if (tx_ack && !tx_req) tx_ack <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_accept) begin
                        r_tx_shift <= tx_byte;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        tx         <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bits  <= 3'd0;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        if (r_tx_bits == 3'd7) begin
                            tx         <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            tx         <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bits  <= r_tx_bits + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        tx_busy    <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_byte_link.md
# uart_byte_link

Byte-level serial link between the board's FTDI pins and the Ackie debug engine. It deserialises 8N1 frames from the FTDI RX pin into bytes and serialises bytes from Ackie onto the FTDI TX pin. Both directions use a four-phase req/ack handshake on the 25 MHz board clock. It drives `tx` onto `ftdi[2]`, samples `rx` from `ftdi[1]`, and exchanges `rx_byte`/`tx_byte` with Ackie.

## Interface
- `CLK_FREQ`, 25000000, input clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `DIVISOR`, CLK_FREQ/BAUD (truncated, 217 at defaults), clock cycles per bit; must be ≥ 4

- `Clk`  in  1  board clock (Clk_25MHz); all logic on the rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial input, idle high, asynchronous to `Clk`
- `tx`  out  1  serial output, idle high
- `rx_byte`  out  8  received byte; valid while `rx_req` is high
- `rx_req`  out  1  received byte available (four-phase, this block is master)
- `rx_ack`  in  1  consumer has taken `rx_byte`
- `tx_byte`  in  8  byte to send; sampled when `tx_req` is accepted
- `tx_req`  in  1  send request (four-phase, Ackie is master)
- `tx_ack`  out  1  `tx_byte` has been latched
- `tx_busy`  out  1  transmitter not idle
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: received byte dropped

## Operation
- Reset values: `tx`=1; `rx_byte`=0; `rx_req`, `tx_ack`, `tx_busy`, `frame_err`, `overrun` all 0. FSMs go to IDLE and all counters clear.
- RX synchroniser: two flops on `rx`, reset to 1. All RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised falling edge; the bit counter loads DIVISOR/2.
  - START: at mid-bit, if the line is low, go to DATA with the counter reloaded to DIVISOR. If the line is high, treat it as a glitch and return to IDLE with no error.
  - DATA: sample 8 bits LSB first, each DIVISOR cycles apart, into a shift register.
  - STOP: sample at mid-stop-bit. If high, the byte is complete. If low, pulse `frame_err`, discard the byte, and go to IDLE.
- RX handshake: on completion with `rx_req` low, load `rx_byte` and raise `rx_req`. Drop `rx_req` on the cycle after `rx_ack` is seen high. A new `rx_req` may only rise after `rx_ack` has been seen low. If completion occurs while `rx_req` is high or `rx_ack` is still high, pulse `overrun` and drop the new byte; `rx_byte` is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - Accept when `tx_req`=1, `tx_ack`=0, and the FSM is IDLE: latch `tx_byte`, set `tx_ack`=1 and `tx_busy`=1, and drive `tx`=0 for DIVISOR cycles.
  - Then send 8 data bits LSB first, then 1 stop bit, each DIVISOR cycles.
  - Return to IDLE and drop `tx_busy`.
- `tx_ack` drops on the cycle after `tx_req` is seen low. A new request is not accepted until both the FSM is IDLE and `tx_ack`=0.
- RX and TX are fully independent and full-duplex.
- Reset asserted mid-frame aborts both directions immediately: `tx` returns to 1 and any partial byte is lost.

## Timing
- TX frame: exactly 10×DIVISOR cycles from the accept edge to IDLE. `tx` changes only on bit boundaries.
- RX latency: `rx_req` rises 2 cycles (synchroniser) + 9.5×DIVISOR (±1) cycles after the line's falling start edge.
- `frame_err` and `overrun` are single-cycle pulses, asserted on the same edge the stop bit is evaluated.
- All outputs are registered.

## Configuration
- `UART_RX_FIFO_EN` defined: a 4-entry RX FIFO sits between the RX FSM and the handshake.
  - Completed bytes are pushed into the FIFO.
  - The handshake presents the FIFO head and pops it on the `rx_ack` rise.
  - `overrun` pulses only when a byte completes with the FIFO full; that byte is dropped.
  - A push and a pop in the same cycle are both honoured.
- `UART_RX_FIFO_EN` undefined: single holding register with the overrun rule given above.

## Structure
- Shared package/defines file holds: RX FSM state encodings, TX FSM state encodings, the `DIVISOR` computation macro, and the FIFO depth constant (4).
- One sub-module, `uart_bit_timer`: a loadable down-counter that gives a tick at each bit boundary and at mid-bit. It is instantiated once for RX and once for TX.

## Test plan
Run with CLK_FREQ=16, BAUD=1, so DIVISOR=16.
- Reset, then tx_byte=0x55 and a tx_req handshake → `tx` shows the pattern 0,1,0,1,0,1,0,1,0,1,1, with each bit 16 cycles wide. `tx_ack` rises 1 cycle after `tx_req`. `tx_busy` stays high for 160 cycles.
- Drive a 0xA3 frame on `rx` → `rx_req` rises with `rx_byte`=0xA3 at 2+152±1 cycles. Assert `rx_ack` → `rx_req` drops 1 cycle later.
- Frame 0x3C with the stop bit low → one `frame_err` pulse, and `rx_req` stays 0.
- 8-cycle low glitch on `rx` → no `rx_req` and no `frame_err`.
- Two frames, 0x11 then 0x22, with `rx_ack` held low:
  - FIFO off: `rx_byte`=0x11 and one `overrun` pulse.
  - FIFO on: 0x11 then 0x22 are delivered and there is no `overrun`.
  - FIFO on, 6 frames sent: 4 are delivered and there are 2 `overrun` pulses.
- Assert `Reset` halfway through a TX frame → `tx`=1 and `tx_busy`=0 immediately. A following request for 0x0F transmits correctly.
